// File: rtl/queue_pop_stage.sv
// rtl/queue_pop_stage.sv - grant-to-pop stage with 2-entry in-order output buffer
//
// Purpose: turns each arbiter grant into a one-hot FIFO pop and captures the
// popped word one cycle later. Captured words are presented on a valid/ready
// output, in order, tagged with their queue id. A grant aimed at an empty queue
// is flagged with a one-cycle error pulse.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous reset, active low
//   i_enb           stage enable (gates new pops only)
//   i_selector      granted queue index
//   i_selector_enb  grant valid this cycle
//   i_buf_empty     per-queue FIFO empty flags
//   i_fifo_data     per-queue FIFO read data, queue i at [i*DATA_BITS +: DATA_BITS]
//   o_pop           one-hot FIFO read strobe (combinational)
//   o_data_out      head word of the output buffer
//   o_data_out_qid  queue id of the head word
//   o_valid_out     head word valid
//   i_ready_in      downstream accepts the head word
//   o_empty_err     one-cycle pulse: previous grant hit an empty queue
module queue_pop_stage #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  localparam int SEL_W         = $clog2(QUEUE_QUANTITY)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_enb,
  input  logic [SEL_W-1:0]                    i_selector,
  input  logic                                i_selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]           i_buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] i_fifo_data,
  output logic [QUEUE_QUANTITY-1:0]           o_pop,
  output logic [DATA_BITS-1:0]                o_data_out,
  output logic [SEL_W-1:0]                    o_data_out_qid,
  output logic                                o_valid_out,
  input  logic                                i_ready_in,
  output logic                                o_empty_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  occ_t                 r_state;
  occ_t                 w_state_nxt;

  // A pop issued last cycle; its word lands on i_fifo_data this cycle.
  logic                 r_inflight;
  logic [SEL_W-1:0]     r_inflight_qid;

  logic [DATA_BITS-1:0] r_head_data;
  logic [SEL_W-1:0]     r_head_qid;
  logic [DATA_BITS-1:0] r_tail_data;
  logic [SEL_W-1:0]     r_tail_qid;
  logic                 r_empty_err;

  logic                 w_deq;
  logic [2:0]           w_occ;
  logic [2:0]           w_committed;
  logic                 w_credit_ok;
  logic                 w_grant;
  logic                 w_sel_empty;
  logic                 w_pop_ok;
  logic [DATA_BITS-1:0] w_cap_data;

  assign w_deq = o_valid_out & i_ready_in;

  always_comb begin
    w_occ = 3'd0;
    case (r_state)
      S_ONE:   w_occ = 3'd1;
      S_TWO:   w_occ = 3'd2;
      default: w_occ = 3'd0;
    endcase
  end

  // Words already held plus the one in flight, minus the one leaving now, must
  // leave a free slot for the word this pop will deliver next cycle.
  assign w_committed = w_occ + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_credit_ok = (w_committed < 3'd2);

  // i_rst in the grant term keeps pop low for the whole time reset is held.
  assign w_grant     = i_rst & i_enb & i_selector_enb;
  assign w_sel_empty = i_buf_empty[i_selector];
  assign w_pop_ok    = w_grant & ~w_sel_empty & w_credit_ok;
  assign o_pop       = w_pop_ok ? (QUEUE_QUANTITY'(1) << i_selector) : '0;

  assign w_cap_data  = i_fifo_data[int'(r_inflight_qid)*DATA_BITS +: DATA_BITS];

  // Occupancy FSM: state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy FSM: next state (r_inflight is the capture strobe)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (r_inflight) w_state_nxt = S_ONE;
      S_ONE: begin
        if (r_inflight && !w_deq)      w_state_nxt = S_TWO;
        else if (!r_inflight && w_deq) w_state_nxt = S_EMPTY;
      end
      S_TWO:   if (w_deq && !r_inflight) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Occupancy FSM: outputs
  always_comb begin
    o_valid_out = 1'b0;
    case (r_state)
      S_ONE, S_TWO: o_valid_out = 1'b1;
      default:      o_valid_out = 1'b0;
    endcase
  end

  // Buffer storage: head is always the oldest word; tail only used in S_TWO.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_head_data <= '0;
      r_head_qid  <= '0;
      r_tail_data <= '0;
      r_tail_qid  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (r_inflight) begin
            r_head_data <= w_cap_data;
            r_head_qid  <= r_inflight_qid;
          end
        end
        S_ONE: begin
          if (r_inflight) begin
            if (w_deq) begin
              r_head_data <= w_cap_data;
              r_head_qid  <= r_inflight_qid;
            end else begin
              r_tail_data <= w_cap_data;
              r_tail_qid  <= r_inflight_qid;
            end
          end
        end
        S_TWO: begin
          if (w_deq) begin
            r_head_data <= r_tail_data;
            r_head_qid  <= r_tail_qid;
          end
          if (r_inflight) begin
            r_tail_data <= w_cap_data;
            r_tail_qid  <= r_inflight_qid;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Reset drops any in-flight pop: that FIFO word is lost by design.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_inflight     <= 1'b0;
      r_inflight_qid <= '0;
      r_empty_err    <= 1'b0;
    end else begin
      r_inflight     <= w_pop_ok;
      r_inflight_qid <= i_selector;
      r_empty_err    <= i_enb & i_selector_enb & w_sel_empty;
    end
  end

  assign o_data_out     = r_head_data;
  assign o_data_out_qid = r_head_qid;
  assign o_empty_err    = r_empty_err;

endmodule

// File: tb/tb_queue_pop_stage.sv
// tb/tb_queue_pop_stage.sv - self-checking bench for queue_pop_stage
module tb_queue_pop_stage;
  localparam int QQ = 4;
  localparam int DB = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enb;
  logic [SW-1:0]  sel;
  logic           sel_enb;
  logic [QQ-1:0]  buf_empty;
  logic [QQ*DB-1:0] fifo_data;
  logic [QQ-1:0]  pop;
  logic [DB-1:0]  data_out;
  logic [SW-1:0]  data_out_qid;
  logic           valid_out;
  logic           ready_in;
  logic           empty_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  queue_pop_stage #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) dut (
    .i_clk(clk), .i_rst(rst), .i_enb(enb), .i_selector(sel),
    .i_selector_enb(sel_enb), .i_buf_empty(buf_empty), .i_fifo_data(fifo_data),
    .o_pop(pop), .o_data_out(data_out), .o_data_out_qid(data_out_qid),
    .o_valid_out(valid_out), .i_ready_in(ready_in), .o_empty_err(empty_err)
  );

  // Bench FIFOs: 1-cycle read latency, word = base + number of earlier pops.
  logic [DB-1:0] base [QQ];
  logic [DB-1:0] pcnt [QQ] = '{default: '0};
  logic [DB-1:0] fifo_word [QQ] = '{default: '0};

  always @(posedge clk) begin
    for (int q = 0; q < QQ; q++) begin
      if (pop[q]) begin
        fifo_word[q] <= base[q] + pcnt[q];
        pcnt[q]      <= pcnt[q] + 8'd1;
      end
    end
  end

  always_comb begin
    fifo_data = '0;
    for (int q = 0; q < QQ; q++) fifo_data[q*DB +: DB] = fifo_word[q];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: list of buffered words plus one pending FIFO read.
  typedef struct packed {
    logic [SW-1:0] qid;
    logic [DB-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  bit            m_infl = 0;
  logic [SW-1:0] m_infl_qid = '0;
  bit            m_err = 0;
  bit            m_deq;
  int            m_used;
  logic [QQ-1:0] m_pop;
  ent_t          m_ent;

  always @(negedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_infl = 0;
      m_err  = 0;
      chk("rst_pop", 32'(pop), 32'(0));
      chk("rst_valid", 32'(valid_out), 32'(0));
      chk("rst_err", 32'(empty_err), 32'(0));
    end else begin
      m_deq  = (m_q.size() > 0) && ready_in;
      m_used = m_q.size() + (m_infl ? 1 : 0) - (m_deq ? 1 : 0);
      m_pop  = (enb && sel_enb && !buf_empty[sel] && m_used < 2) ? (QQ'(1) << sel) : '0;
      chk("m_pop", 32'(pop), 32'(m_pop));
      chk("m_valid", 32'(valid_out), 32'(m_q.size() > 0));
      chk("m_err", 32'(empty_err), 32'(m_err));
      if (m_q.size() > 0) begin
        chk("m_data", 32'(data_out), 32'(m_q[0].data));
        chk("m_qid", 32'(data_out_qid), 32'(m_q[0].qid));
      end
      if (m_deq) void'(m_q.pop_front());
      if (m_infl) begin
        m_ent.qid  = m_infl_qid;
        m_ent.data = fifo_word[m_infl_qid];
        m_q.push_back(m_ent);
      end
      chk("m_occ_le2", 32'(m_q.size() <= 2), 32'(1));
      m_infl     = (m_pop != 0);
      m_infl_qid = sel;
      m_err      = enb && sel_enb && buf_empty[sel];
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      to_neg();
      to_drive();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int npop;
  int nvalid;

  initial begin
    rst = 1'b0; enb = 1'b1; sel = '0; sel_enb = 1'b1; buf_empty = '0; ready_in = 1'b1;
    for (int q = 0; q < QQ; q++) base[q] = 8'(8'h10 * (q + 1));

    // 1: reset holds pop low; release pops in the same cycle
    to_neg();
    chk("t1_rst_pop", 32'(pop), 32'h0);
    chk("t1_rst_valid", 32'(valid_out), 32'h0);
    chk("t1_rst_err", 32'(empty_err), 32'h0);
    to_drive();
    rst = 1'b1;
    to_neg();
    chk("t1_first_pop", 32'(pop), 32'h1);
    to_drive();
    sel_enb = 1'b0;
    idle(3);

    // 2: single word from queue 2
    base[2] = 8'hA5 - pcnt[2];
    sel = 2'd2; sel_enb = 1'b1;
    to_neg();
    chk("t2_pop", 32'(pop), 32'h4);
    to_drive();
    sel_enb = 1'b0;
    to_neg();
    chk("t2_valid_t1", 32'(valid_out), 32'h0);
    to_drive();
    to_neg();
    chk("t2_valid_t2", 32'(valid_out), 32'h1);
    chk("t2_data", 32'(data_out), 32'hA5);
    chk("t2_qid", 32'(data_out_qid), 32'h2);
    to_drive();
    to_neg();
    chk("t2_valid_t3", 32'(valid_out), 32'h0);
    to_drive();

    // 3: streaming round-robin, one pop and one output per cycle
    npop = 0; nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      sel = SW'(i % 4); sel_enb = 1'b1;
      to_neg();
      if (pop != 0) npop++;
      if (valid_out) nvalid++;
      to_drive();
    end
    chk("t3_pops", 32'(npop), 32'd12);
    chk("t3_valids", 32'(nvalid), 32'd10);
    sel_enb = 1'b0;
    idle(3);

    // 4: backpressure stops after two pops, resumes on ready
    ready_in = 1'b0; sel = 2'd3; sel_enb = 1'b1; npop = 0;
    for (int i = 0; i < 6; i++) begin
      to_neg();
      if (pop != 0) npop++;
      to_drive();
    end
    chk("t4_pops", 32'(npop), 32'd2);
    ready_in = 1'b1;
    to_neg();
    chk("t4_valid", 32'(valid_out), 32'h1);
    chk("t4_resume", 32'(pop), 32'h8);
    to_drive();
    idle(3);
    sel_enb = 1'b0;
    idle(4);

    // 5: grant to an empty queue, then the same with enb low
    buf_empty = 4'b0010; sel = 2'd1; sel_enb = 1'b1;
    to_neg();
    chk("t5_pop", 32'(pop), 32'h0);
    to_drive();
    sel_enb = 1'b0;
    to_neg();
    chk("t5_err", 32'(empty_err), 32'h1);
    chk("t5_valid", 32'(valid_out), 32'h0);
    to_drive();
    to_neg();
    chk("t5_err_clr", 32'(empty_err), 32'h0);
    to_drive();
    enb = 1'b0; sel_enb = 1'b1;
    to_neg();
    to_drive();
    sel_enb = 1'b0;
    to_neg();
    chk("t5_enb0_err", 32'(empty_err), 32'h0);
    to_drive();
    enb = 1'b1; buf_empty = '0;

    // 6: reset the cycle after a pop discards the in-flight word
    sel = 2'd0; sel_enb = 1'b1;
    to_neg();
    chk("t6_pop", 32'(pop), 32'h1);
    to_drive();
    sel_enb = 1'b0; rst = 1'b0;
    to_neg();
    to_drive();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("t6_valid", 32'(valid_out), 32'h0);
      to_drive();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
